// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared constants, entry record and state encoding for the scrolling display
package sseg_pkg;

  localparam int         MSG_DEPTH  = 16;
  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;

  // One message entry as written by the host
  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] hex;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STATIC = 2'd1,
    ST_SCROLL = 2'd2
  } state_e;

  // Display mode implied by a message length
  function automatic state_e state_for_len(input logic [4:0] len);
    if (len == 5'd0) begin
      return ST_IDLE;
    end else if (len <= 5'(NUM_DIGITS)) begin
      return ST_STATIC;
    end else begin
      return ST_SCROLL;
    end
  endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// rtl/hex_to_sseg.sv - combinational entry to active-low segment byte decoder
module hex_to_sseg
  import sseg_pkg::*;
(
  input  entry_t     entry_i,
  output logic [7:0] seg_o
);

  logic [6:0] seg7;

  // Active-low gfedcba pattern; a blank entry lights no segment but keeps its dp
  always_comb begin
    seg7 = 7'h7F;
    if (!entry_i.blank) begin
      case (entry_i.hex)
        4'h0: seg7 = 7'b1000000;
        4'h1: seg7 = 7'b1111001;
        4'h2: seg7 = 7'b0100100;
        4'h3: seg7 = 7'b0110000;
        4'h4: seg7 = 7'b0011001;
        4'h5: seg7 = 7'b0010010;
        4'h6: seg7 = 7'b0000010;
        4'h7: seg7 = 7'b1111000;
        4'h8: seg7 = 7'b0000000;
        4'h9: seg7 = 7'b0010000;
        4'hA: seg7 = 7'b0001000;
        4'hB: seg7 = 7'b0000011;
        4'hC: seg7 = 7'b1000110;
        4'hD: seg7 = 7'b0100001;
        4'hE: seg7 = 7'b0000110;
        4'hF: seg7 = 7'b0001110;
      endcase
    end
    seg_o = {~entry_i.dp, seg7};
  end

endmodule

// File: rtl/sseg_scroll.sv
// rtl/sseg_scroll.sv - 16-entry message buffer shown on 8 digits, scrolling when longer than 8 (blank gap: SSEG_SCROLL_GAP_EN)
module sseg_scroll
  import sseg_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_hex,
  input  logic       wr_dp,
  input  logic       wr_blank,
  input  logic       pause,
  output logic [7:0] dig7,
  output logic [7:0] dig6,
  output logic [7:0] dig5,
  output logic [7:0] dig4,
  output logic [7:0] dig3,
  output logic [7:0] dig2,
  output logic [7:0] dig1,
  output logic [7:0] dig0,
  output logic [4:0] msg_len
);

  localparam int                TICK_W    = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [4:0]        DEPTH     = 5'(MSG_DEPTH);

  entry_t            msg_q [MSG_DEPTH];
  logic [4:0]        len_q, len_d;
  logic [4:0]        start_q, start_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  state_e            state_q, state_d;
  logic [7:0]        dig_q [NUM_DIGITS];

  logic              wr_fire;
  logic [4:0]        period_w;
  logic [4:0]        pos_w  [NUM_DIGITS];
  logic              show_w [NUM_DIGITS];
  entry_t            ent_w  [NUM_DIGITS];
  logic [7:0]        seg_w  [NUM_DIGITS];

  // Write handshake, next length/mode and scroll pointer advance
  always_comb begin
    wr_ready = !rst && !clr && (len_q < DEPTH);
    wr_fire  = wr_valid && wr_ready;
    len_d    = clr ? 5'd0 : len_q + 5'(wr_fire);
    state_d  = state_for_len(len_d);
`ifdef SSEG_SCROLL_GAP_EN
    period_w = len_q + 5'(NUM_DIGITS);
`else
    period_w = len_q;
`endif
    start_d  = start_q;
    tick_d   = tick_q;
    if ((state_d != ST_SCROLL) || (state_q != ST_SCROLL)) begin
      // Outside scrolling, or just entering it: the window restarts at entry 0
      start_d = 5'd0;
      tick_d  = '0;
    end else if (!pause) begin
      if (tick_q == TICK_LAST) begin
        tick_d  = '0;
        start_d = ((start_q + 5'd1) >= period_w) ? 5'd0 : start_q + 5'd1;
      end else begin
        tick_d  = tick_q + 1'b1;
      end
    end
  end

  // Buffer position shown on each digit; positions past the message stay dark
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      pos_w[k] = 5'(k);
      if (state_q == ST_SCROLL) begin
        pos_w[k] = start_q + 5'(k);
        if (pos_w[k] >= period_w) begin
          pos_w[k] = pos_w[k] - period_w;
        end
      end
      show_w[k] = (state_q != ST_IDLE) && (pos_w[k] < len_q);
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
    assign ent_w[k] = msg_q[pos_w[k][3:0]];
    hex_to_sseg u_dec (
      .entry_i (ent_w[k]),
      .seg_o   (seg_w[k])
    );
  end

  // Message storage needs no reset: a zero length hides every stored entry
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      msg_q[len_q[3:0]] <= '{blank: wr_blank, dp: wr_dp, hex: wr_hex};
    end
  end

  // Mode FSM, scroll pointer/timer and registered digit outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= 5'd0;
      start_q <= 5'd0;
      tick_q  <= '0;
      state_q <= ST_IDLE;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        dig_q[k] <= SEG_BLANK;
      end
    end else begin
      len_q   <= len_d;
      start_q <= start_d;
      tick_q  <= tick_d;
      state_q <= state_d;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        dig_q[k] <= show_w[k] ? seg_w[k] : SEG_BLANK;
      end
    end
  end

  assign dig7    = dig_q[0];
  assign dig6    = dig_q[1];
  assign dig5    = dig_q[2];
  assign dig4    = dig_q[3];
  assign dig3    = dig_q[4];
  assign dig2    = dig_q[5];
  assign dig1    = dig_q[6];
  assign dig0    = dig_q[7];
  assign msg_len = len_q;

endmodule
